acc_mem_responder: RTL and testbench

//  Memory-side responder for the accelerator request bus (acc_valid/acc_addr/acc_wdata/acc_wstrb -> acc_ready/acc_rdata/acc_rvalid).

---
 rtl/acc_mem_responder.sv | 153 +++++++++++++++
 tb/tb_acc_mem_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/acc_mem_responder.sv
// acc_mem_responder
//   Memory-side responder for the accelerator request bus. It serves
//   word-addressed reads and byte-strobed writes from an internal
//   FE_DATA_W-wide array. Read latency is fixed at RD_LAT cycles,
//   responses come back in accept order, and the number of accepted but
//   unreturned reads is limited to MAX_OUTSTANDING.
//
// Ports
//   clk         in   1          clock, posedge
//   rst_n       in   1          asynchronous active-low reset
//   acc_valid   in   1          request valid
//   acc_addr    in   FE_ADDR_W  word address
//   acc_wdata   in   FE_DATA_W  write data
//   acc_wstrb   in   FE_STRB_W  byte strobes (all-zero = read)
//   acc_ready   out  1          registered accept indication
//   acc_rdata   out  FE_DATA_W  read data, meaningful while acc_rvalid=1
//   acc_rvalid  out  1          one-cycle pulse per read response
//   err         out  1          sticky out-of-range access flag
//
// Build option
//   ACC_RESP_STALL_EN : adds a 16-bit LFSR that randomly withholds ready
//                       for backpressure testing.
module acc_mem_responder #(
    parameter int DEPTH           = 256,
    parameter int RD_LAT          = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int FE_ADDR_W       = 32,
    parameter int FE_DATA_W       = 256,
    parameter int FE_STRB_W       = FE_DATA_W / 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 acc_valid,
    input  logic [FE_ADDR_W-1:0] acc_addr,
    input  logic [FE_DATA_W-1:0] acc_wdata,
    input  logic [FE_STRB_W-1:0] acc_wstrb,
    output logic                 acc_ready,
    output logic [FE_DATA_W-1:0] acc_rdata,
    output logic                 acc_rvalid,
    output logic                 err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OC_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OC_W-1:0] MAX_OC = OC_W'(MAX_OUTSTANDING);

    logic [FE_DATA_W-1:0] mem [DEPTH];

    logic                 ready_q,  ready_d;
    logic [OC_W-1:0]      oc_q,     oc_d;
    logic [RD_LAT-1:0]    pipe_vld_q;
    logic [FE_DATA_W-1:0] pipe_dat_q [RD_LAT];
    logic                 rvalid_q;
    logic [FE_DATA_W-1:0] rdata_q;
    logic                 err_q;

    logic [IDX_W-1:0]     idx;
    logic                 oor;
    logic                 accept;
    logic                 wr_acc;
    logic                 rd_acc;
    logic [FE_DATA_W-1:0] rd_data;

    assign idx     = acc_addr[IDX_W-1:0];
    assign oor     = |acc_addr[FE_ADDR_W-1:IDX_W];
    assign accept  = acc_valid && ready_q;
    assign wr_acc  = accept && (|acc_wstrb);
    assign rd_acc  = accept && !(|acc_wstrb);
    // Out-of-range reads still travel the pipe so their timing is normal.
    assign rd_data = oor ? '0 : mem[idx];

`ifdef ACC_RESP_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    // Outstanding count and registered ready.
    always_comb begin
        oc_d = oc_q;
        if (rd_acc && !rvalid_q) begin
            oc_d = oc_q + OC_W'(1);
        end else if (!rd_acc && rvalid_q) begin
            oc_d = oc_q - OC_W'(1);
        end
`ifdef ACC_RESP_STALL_EN
        // The stall bit is taken from the LFSR value that will be current
        // while this ready is visible, keeping ready purely registered.
        ready_d = (oc_d < MAX_OC) && lfsr_d[0];
`else
        ready_d = (oc_d < MAX_OC);
`endif
    end

    // ---- stage boundary: accept edge -> latency pipe ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            oc_q       <= '0;
            pipe_vld_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            ready_q       <= ready_d;
            oc_q          <= oc_d;
            pipe_vld_q[0] <= rd_acc;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
            // ---- stage boundary: pipe tail -> response outputs ----
            rvalid_q <= pipe_vld_q[RD_LAT-1];
            if (pipe_vld_q[RD_LAT-1]) begin
                rdata_q <= pipe_dat_q[RD_LAT-1];
            end
            if (accept && oor) begin
                err_q <= 1'b1;
            end
        end
    end

    // Data side: no reset, contents survive rst_n.
    always_ff @(posedge clk) begin
        pipe_dat_q[0] <= rd_data;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_dat_q[i] <= pipe_dat_q[i-1];
        end
        if (wr_acc && !oor) begin
            for (int b = 0; b < FE_STRB_W; b++) begin
                if (acc_wstrb[b]) begin
                    mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    assign acc_ready  = ready_q;
    assign acc_rvalid = rvalid_q;
    assign acc_rdata  = rdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_acc_mem_responder.sv
module tb_acc_mem_responder;

    localparam int DEPTH  = 16;
    localparam int RD_LAT = 8;
    localparam int MAXO   = 4;
    localparam int AW     = 8;
    localparam int DW     = 256;
    localparam int SW     = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          acc_valid = 1'b0;
    logic [AW-1:0] acc_addr = '0;
    logic [DW-1:0] acc_wdata = '0;
    logic [SW-1:0] acc_wstrb = '0;
    logic          acc_ready;
    logic [DW-1:0] acc_rdata;
    logic          acc_rvalid;
    logic          acc_err;

    acc_mem_responder #(
        .DEPTH(DEPTH), .RD_LAT(RD_LAT), .MAX_OUTSTANDING(MAXO),
        .FE_ADDR_W(AW), .FE_DATA_W(DW), .FE_STRB_W(SW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .acc_valid(acc_valid), .acc_addr(acc_addr),
        .acc_wdata(acc_wdata), .acc_wstrb(acc_wstrb),
        .acc_ready(acc_ready), .acc_rdata(acc_rdata),
        .acc_rvalid(acc_rvalid), .err(acc_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain array, queue of due responses, sticky flag.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } resp_t;

    logic [DW-1:0] mem_m [DEPTH];
    resp_t         exp_q [$];
    logic          err_m = 1'b0;
    logic          last_acc;
    logic [DW-1:0] last_rd;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: compare outputs of the current cycle, apply the model for
    // the coming edge, then step past that edge.
    task automatic tick();
        logic  exp_rv;
        resp_t r;
        @(negedge clk);
        exp_rv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
`ifndef ACC_RESP_STALL_EN
        check("ready", acc_ready, (exp_q.size() < MAXO));
`endif
        check("rvalid", acc_rvalid, exp_rv);
        if (exp_rv) begin
            check("rdata", acc_rdata, exp_q[0].data);
            last_rd = acc_rdata;
            void'(exp_q.pop_front());
        end
        check("err", acc_err, err_m);
        last_acc = acc_valid && acc_ready;
        if (last_acc) begin
            if (acc_addr >= DEPTH) begin
                err_m = 1'b1;
                if (acc_wstrb == '0) begin
                    r.due  = cyc + 1 + RD_LAT;
                    r.data = '0;
                    exp_q.push_back(r);
                end
            end else if (acc_wstrb != '0) begin
                for (int b = 0; b < SW; b++)
                    if (acc_wstrb[b]) mem_m[acc_addr[3:0]][8*b +: 8] = acc_wdata[8*b +: 8];
            end else begin
                r.due  = cyc + 1 + RD_LAT;
                r.data = mem_m[acc_addr[3:0]];
                exp_q.push_back(r);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [SW-1:0] s, input logic [DW-1:0] d);
        int n;
        acc_valid = 1'b1;
        acc_addr  = a;
        acc_wstrb = s;
        acc_wdata = d;
        n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 60) begin
            tick();
            n++;
        end
        if (!last_acc) check("accept_timeout", 0, 1);
        acc_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) w[32*k +: 32] = $urandom;
        return w;
    endfunction

    initial begin
        int            acc_cnt;
        logic [DW-1:0] w;
        logic [SW-1:0] s;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", acc_ready, 0);
        check("rst_rvalid", acc_rvalid, 0);
        check("rst_rdata", acc_rdata, 0);
        check("rst_err", acc_err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) send(AW'(i), '1, rand_word());

        // Lane-0 write then read back.
        send(8'd5, 32'h0000_000F, {224'h0, 32'hDEAD_BEEF});
        send(8'd5, '0, '0);
        idle(RD_LAT + 2);
        check("deadbeef_lane0", {224'h0, last_rd[31:0]}, {224'h0, 32'hDEAD_BEEF});

        // Partial strobe: only first and last bytes change.
        send(8'd3, '1, {32{8'h11}});
        send(8'd3, 32'h8000_0001, '1);
        send(8'd3, '0, '0);
        idle(RD_LAT + 2);
        check("partial_strobe", last_rd, {8'hFF, {30{8'h11}}, 8'hFF});

        // Outstanding limit: valid held through the full latency window.
        acc_valid = 1'b1;
        acc_wstrb = '0;
        acc_addr  = 8'd0;
        acc_cnt   = 0;
        for (int i = 0; i < RD_LAT + 1; i++) begin
            tick();
            if (last_acc) begin
                acc_cnt++;
                acc_addr = AW'(acc_cnt);
            end
        end
`ifndef ACC_RESP_STALL_EN
        check("outstanding_accepts", acc_cnt, MAXO);
`endif
        acc_valid = 1'b0;
        idle(RD_LAT + 4);

        // Out-of-range read: zero data, sticky error.
        send(AW'(DEPTH), '0, rand_word());
        idle(RD_LAT + 4);
        check("oor_err_sticky", acc_err, 1);

        // Reset with two reads in flight.
        send(8'd1, '0, '0);
        send(8'd2, '0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rvalid", acc_rvalid, 0);
        check("midrst_ready", acc_ready, 0);
        check("midrst_err", acc_err, 0);
        exp_q.delete();
        err_m = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_hold_rvalid", acc_rvalid, 0);
        rst_n = 1'b1;
        #1;
        check("release_ready_low", acc_ready, 0);
        @(posedge clk);
        #1;
        idle(RD_LAT + 4);

        // Random mixed traffic, including out-of-range addresses.
        for (int i = 0; i < 400; i++) begin
            w = rand_word();
            s = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom);
            send(AW'($urandom_range(0, DEPTH + 2)), s, w);
            idle($urandom_range(0, 2));
        end
        idle(RD_LAT + 4);
        check("final_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
